// File: rtl/instr_mem_loader.sv
// Writable MIPS instruction memory fed by a byte-stream loader (MSB-first word assembly).
// Define INSTR_MEM_LOADER_CHECKSUM_EN to enable the per-session 32-bit word checksum.
module instr_mem_loader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             byte_last,
  output logic             byte_ready,
  input  logic [WIDTH-1:0] address,
  output logic [31:0]      RD,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [WIDTH:0]   words_loaded,
  output logic             cpu_hold,
  output logic [31:0]      checksum
);

  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH:0] DEPTH_W = (WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t         state_reg, state_next;
  logic [31:0]    word_reg, word_next;
  logic [1:0]     cnt_reg, cnt_next;
  logic           last_reg, last_next;
  logic [WIDTH:0] ptr_reg, ptr_next;
  logic           overflow_reg, overflow_next;
  logic           mem_we;
  logic [31:0]    shifted_word;
  logic [31:0]    padded_word;

  logic [31:0] mem [DEPTH];

  // A short final word is left-justified: shift out the (3 - cnt) unfilled byte lanes.
  assign shifted_word = {word_reg[23:0], byte_in};
  assign padded_word  = byte_last ? (shifted_word << {~cnt_reg, 3'b000}) : shifted_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      cnt_reg      <= '0;
      last_reg     <= 1'b0;
      ptr_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_reg     <= word_next;
      cnt_reg      <= cnt_next;
      last_reg     <= last_next;
      ptr_reg      <= ptr_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    word_next     = word_reg;
    cnt_next      = cnt_reg;
    last_next     = last_reg;
    ptr_next      = ptr_reg;
    overflow_next = overflow_reg;
    mem_we        = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (state_reg == IDLE || start) begin
          word_next     = '0;
          cnt_next      = '0;
          last_next     = 1'b0;
          ptr_next      = '0;
          overflow_next = 1'b0;
        end
        if (start) state_next = LOAD;
      end
      LOAD: begin
        if (byte_valid) begin
          word_next = padded_word;
          cnt_next  = cnt_reg + 2'd1;
          last_next = byte_last;
          if (cnt_reg == 2'd3 || byte_last) state_next = WRITE;
        end
      end
      WRITE: begin
        word_next = '0;
        cnt_next  = '0;
        // The pointer saturates at DEPTH; a word arriving there is dropped.
        if (ptr_reg == DEPTH_W) begin
          overflow_next = 1'b1;
          state_next    = DONE;
        end else begin
          mem_we     = 1'b1;
          ptr_next   = ptr_reg + 1'b1;
          state_next = last_reg ? DONE : LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem[ptr_reg[AW-1:0]] <= word_reg;
  end

  assign RD = ({1'b0, address} < DEPTH_W) ? mem[address[AW-1:0]] : 32'h0;

  assign byte_ready   = (state_reg == LOAD);
  assign busy         = (state_reg == LOAD) || (state_reg == WRITE);
  assign cpu_hold     = busy;
  assign done         = (state_reg == DONE);
  assign overflow     = overflow_reg;
  assign words_loaded = ptr_reg;

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [31:0] cksum_reg;
  logic        session_clear;

  assign session_clear = start && (state_reg == IDLE || state_reg == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n)             cksum_reg <= '0;
    else if (session_clear) cksum_reg <= '0;
    else if (mem_we)        cksum_reg <= cksum_reg + word_reg;
  end

  assign checksum = cksum_reg;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a byte-list level model.
// Checksum expectations follow INSTR_MEM_LOADER_CHECKSUM_EN as defined for the build.
module tb_instr_mem_loader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       byte_in = 8'h0;
  logic             byte_valid = 1'b0;
  logic             byte_last = 1'b0;
  logic             byte_ready;
  logic [WIDTH-1:0] address = '0;
  logic [31:0]      RD;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [WIDTH:0]   words_loaded;
  logic             cpu_hold;
  logic [31:0]      checksum;

  instr_mem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .address(address), .RD(RD), .busy(busy), .done(done), .overflow(overflow),
    .words_loaded(words_loaded), .cpu_hold(cpu_hold), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          accepted;
  logic [31:0] model_mem [DEPTH];
  bit          model_valid [DEPTH];
  logic [7:0]  sess_bytes [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) sess_bytes.push_back(8'(w >> (8 * b)));
  endtask

  task automatic check_reset_values(input string name);
    check_eq({name, "/byte_ready"}, 32'(byte_ready), 0);
    check_eq({name, "/busy"}, 32'(busy), 0);
    check_eq({name, "/cpu_hold"}, 32'(cpu_hold), 0);
    check_eq({name, "/done"}, 32'(done), 0);
    check_eq({name, "/overflow"}, 32'(overflow), 0);
    check_eq({name, "/words_loaded"}, 32'(words_loaded), 0);
    check_eq({name, "/checksum"}, checksum, 0);
  endtask

  // Expected session outcome derived from the byte list alone.
  task automatic model_check(input string name);
    int          n;
    int          nw;
    int          written;
    int          exp_acc;
    bit          ovf;
    logic [31:0] sum;
    logic [31:0] w;
    n       = sess_bytes.size();
    nw      = (n + 3) / 4;
    ovf     = (nw > DEPTH);
    written = ovf ? DEPTH : nw;
    exp_acc = ovf ? 4 * (DEPTH + 1) : n;
    sum     = 0;
    for (int i = 0; i < written; i++) begin
      w = 0;
      for (int b = 0; b < 4; b++) begin
        w = w << 8;
        if (i * 4 + b < n) w = w | 32'(sess_bytes[i * 4 + b]);
      end
      model_mem[i]   = w;
      model_valid[i] = 1'b1;
      sum            = sum + w;
    end
`ifndef INSTR_MEM_LOADER_CHECKSUM_EN
    sum = 0;
`endif
    check_eq({name, "/accepted"}, 32'(accepted), 32'(exp_acc));
    check_eq({name, "/done"}, 32'(done), 1);
    check_eq({name, "/busy"}, 32'(busy), 0);
    check_eq({name, "/byte_ready"}, 32'(byte_ready), 0);
    check_eq({name, "/overflow"}, 32'(overflow), 32'(ovf));
    check_eq({name, "/words_loaded"}, 32'(words_loaded), 32'(written));
    check_eq({name, "/checksum"}, checksum, sum);
    for (int i = 0; i < DEPTH; i++) begin
      if (model_valid[i]) begin
        address = WIDTH'(i);
        #1;
        check_eq($sformatf("%s/RD@%0d", name, i), RD, model_mem[i]);
      end
    end
    address = WIDTH'($urandom_range(DEPTH, 255));
    #1;
    check_eq($sformatf("%s/RD_oob@%0d", name, address), RD, 0);
  endtask

  // Drives sess_bytes as one session; start is re-pulsed with byte start_at to show it is ignored.
  task automatic run_session(input string name, input int gap_max, input int start_at);
    int n;
    int idx;
    int wait_n;
    int zeros;
    int gap;
    bit stop;
    n    = sess_bytes.size();
    idx  = 0;
    stop = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({name, "/start_busy"}, 32'(busy), 1);
    check_eq({name, "/start_done"}, 32'(done), 0);
    check_eq({name, "/start_overflow"}, 32'(overflow), 0);
    check_eq({name, "/start_words"}, 32'(words_loaded), 0);
    check_eq({name, "/start_checksum"}, checksum, 0);
    byte_in    = sess_bytes[0];
    byte_last  = (n == 1);
    byte_valid = 1'b1;
    while (idx < n && !stop) begin
      wait_n = 0;
      while (!byte_ready && !done && wait_n < 50) begin
        @(negedge clk);
        wait_n++;
      end
      if (wait_n >= 50) begin
        check_eq({name, "/ready_timeout"}, 0, 1);
        stop = 1'b1;
      end else if (done) begin
        stop = 1'b1;
      end else begin
        if (idx == start_at) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx++;
        if (idx < n) begin
          byte_in   = sess_bytes[idx];
          byte_last = (idx == n - 1);
          zeros     = 0;
          while (!byte_ready && !done && zeros < 10) begin
            @(negedge clk);
            zeros++;
          end
          if (!done)
            check_eq($sformatf("%s/ready_gap%0d", name, idx), 32'(zeros), (idx % 4 == 0) ? 1 : 0);
          gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
          if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
            byte_valid = 1'b1;
          end
        end
      end
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    accepted   = idx;
    if (idx == n) begin
      check_eq({name, "/write_busy"}, 32'(busy), 1);
      check_eq({name, "/write_done"}, 32'(done), 0);
      @(negedge clk);
      check_eq({name, "/cpu_hold_off"}, 32'(cpu_hold), 0);
    end
    model_check(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    address = 8'd200;
    #1;
    check_eq("reset/RD_oob", RD, 0);
    rst_n = 1'b1;

    sess_bytes = {8'h20, 8'h01, 8'h00, 8'h03};
    run_session("single", 0, -1);

    sess_bytes = {};
    push_word(32'h20010005); push_word(32'h20020007); push_word(32'h00221020);
    push_word(32'h00412822); push_word(32'h00222024); push_word(32'h00A42825);
    push_word(32'h00A4302A);
    run_session("seven", 0, 5);

    sess_bytes = {8'h12, 8'h34, 8'h56};
    run_session("partial", 1, -1);

    for (int s = 0; s < 6; s++) begin
      sess_bytes = {};
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) sess_bytes.push_back(8'($urandom));
      run_session($sformatf("rand%0d", s), $urandom_range(0, 3), $urandom_range(0, n - 1));
    end

    // Reset two bytes into a load: state drops, memory survives, the next word starts clean.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    byte_in    = 8'hDE;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_in = 8'hAD;
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("midreset");
    rst_n   = 1'b1;
    address = '0;
    #1;
    check_eq("midreset/RD@0_kept", RD, model_mem[0]);
    sess_bytes = {8'hC0, 8'hFF, 8'hEE, 8'h11};
    run_session("after_reset", 0, -1);

    sess_bytes = {};
    for (int i = 0; i < DEPTH + 2; i++) push_word($urandom);
    run_session("overflow", 0, 17);

    sess_bytes = {};
    for (int i = 0; i < 9; i++) sess_bytes.push_back(8'($urandom));
    run_session("restart", 2, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
